// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Bundle of the signals around uart_tx_fifo.
//               Host push side: wr_en, wr_data, ovf_clr in; full, empty,
//               count, overflow, busy out.
//               uart_tx side: tx_start, tx_data out; tx_done in.
//               The master modport is the environment (host and uart_tx).
//               The slave modport is the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              ovf_clr;
    logic              busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;

    modport master (
        output wr_en, wr_data, ovf_clr, tx_done,
        input  full, empty, count, overflow, busy, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_done,
        output full, empty, count, overflow, busy, tx_start, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding uart_tx. The host pushes bytes at clock
//               rate. An FSM pops one byte at a time and hands it to uart_tx
//               with a one-cycle tx_start pulse. It then waits for tx_done.
// Ports       : clk, rst    - system clock, synchronous active-high reset
//               bus (slave) - wr_en/wr_data/ovf_clr in;
//                             full/empty/count/overflow/busy out;
//                             tx_start/tx_data out, tx_done in
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_tx_fifo_if.slave      bus
);
    localparam int                c_depth      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   c_full_count = (ADDR_W + 1)'(c_depth);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Storage is deliberately not reset.
    logic [7:0]        mem [c_depth];

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              overflow_q, overflow_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q,  tx_data_d;

    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_push_drop;
    logic              w_pop;

    always_comb begin
        w_full      = (count_q == c_full_count);
        w_empty     = (count_q == '0);
        // full is taken from the registered count, so a pop in the same
        // cycle cannot make room for the push.
        w_push_ok   = bus.wr_en && !w_full;
        w_push_drop = bus.wr_en &&  w_full;
        // A pop happens only when the FSM leaves IDLE.
        w_pop       = (state_q == S_IDLE) && !w_empty;

        wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, w_push_ok};
        rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, w_pop};

        unique case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // If a dropped push and a clear arrive in the same cycle, the
        // drop is reported.
        if (w_push_drop) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    tx_data_d  = mem[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // tx_done in any other state is ignored.
                if (bus.tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

endmodule
`default_nettype wire
